instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/if_pkg.sv | 30 +++
 rtl/instruction_fetch_if.sv | 37 +++
 rtl/fetch_skid_buffer.sv | 53 +++++
 rtl/instruction_fetch.sv | 165 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// =====================================================================
// if_pkg : shared types and constants for the instruction fetch stage
// Rev 1.0
// =====================================================================
package if_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   localparam logic [1:0] c_JUMP_SEQ  = 2'b00;
   localparam logic [1:0] c_JUMP_J    = 2'b01;
   localparam logic [1:0] c_JUMP_REG  = 2'b10;
   localparam logic [1:0] c_JUMP_RSVD = 2'b11;

   localparam logic [31:0] c_DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] c_DEF_EXC_VECTOR = 32'h8000_0004;
   localparam logic [31:0] c_DEF_INT_VECTOR = 32'h8000_0008;

   localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & c_WORD_MASK;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// =====================================================================
// instruction_fetch_if : ID control, instruction memory and IF/ID bundle
// Rev 1.0
// =====================================================================
interface instruction_fetch_if;

   logic        Stall;
   logic        Branch;
   logic        BranchCond;
   logic [1:0]  Jump;
   logic [31:0] JumpTarget;
   logic [31:0] JumpReg;
   logic        Exception;
   logic        Interrupt;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemReady;
   logic [31:0] ImemData;
   logic [31:0] IFID_Instruction;
   logic [31:0] IFID_PC;
   logic        IFID_Valid;

   modport master (
      input  Stall, Branch, BranchCond, Jump, JumpTarget, JumpReg,
             Exception, Interrupt, ImemReady, ImemData,
      output ImemReq, ImemAddr, IFID_Instruction, IFID_PC, IFID_Valid
   );

   modport slave (
      output Stall, Branch, BranchCond, Jump, JumpTarget, JumpReg,
             Exception, Interrupt, ImemReady, ImemData,
      input  ImemReq, ImemAddr, IFID_Instruction, IFID_PC, IFID_Valid
   );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// =====================================================================
// fetch_skid_buffer : one-entry holding slot for a word returned under stall
// Rev 1.0
// =====================================================================
module fetch_skid_buffer (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        i_load,
   input  wire logic        i_clear,
   input  wire logic [31:0] i_data,
   input  wire logic [31:0] i_pc,
   output logic [31:0]      o_data,
   output logic [31:0]      o_pc,
   output logic             o_valid
);

   logic [31:0] data_q, data_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;

   // Clear wins so a redirect always empties the slot.
   always_comb begin
      data_d  = data_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (i_clear) begin
         valid_d = 1'b0;
      end else if (i_load) begin
         data_d  = i_data;
         pc_d    = i_pc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= 32'h0;
         pc_q    <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign o_data  = data_q;
   assign o_pc    = pc_q;
   assign o_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// =====================================================================
// instruction_fetch : IF stage with stall skid, redirect and discard FSM
// Rev 1.0
// =====================================================================
module instruction_fetch
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = c_DEF_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = c_DEF_EXC_VECTOR,
   parameter logic [31:0] INT_VECTOR = c_DEF_INT_VECTOR
) (
   input  wire logic           clk,
   input  wire logic           reset,
   instruction_fetch_if.master fif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  addr_q, addr_d;
   logic         req_q, req_d;
   logic [31:0]  ifid_instr_q, ifid_instr_d;
   logic [31:0]  ifid_pc_q, ifid_pc_d;
   logic         ifid_valid_q, ifid_valid_d;

   logic         w_skid_load, w_skid_clear, w_skid_valid;
   logic [31:0]  w_skid_data, w_skid_pc;
   logic         w_jump_j, w_jump_r, w_redirect;
   logic [31:0]  w_target;

   always_comb begin
      w_jump_j = 1'b0;
      w_jump_r = 1'b0;
      case (fif.Jump)
         c_JUMP_J:                w_jump_j = 1'b1;
         c_JUMP_REG:              w_jump_r = 1'b1;
         c_JUMP_SEQ, c_JUMP_RSVD: ;
      endcase
      w_redirect = !fif.Stall && (fif.Exception || fif.Interrupt || w_jump_j ||
                                  w_jump_r || (fif.Branch && fif.BranchCond));
      if (fif.Exception)      w_target = word_align(EXC_VECTOR);
      else if (fif.Interrupt) w_target = word_align(INT_VECTOR);
      else if (w_jump_r)      w_target = word_align(fif.JumpReg);
      else                    w_target = word_align(fif.JumpTarget);
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      addr_d       = addr_q;
      req_d        = req_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      w_skid_load  = 1'b0;
      w_skid_clear = 1'b0;

      if (w_redirect) begin
         pc_d         = w_target;
         w_skid_clear = 1'b1;
         ifid_instr_d = 32'h0;
         ifid_pc_d    = pc_q;
         ifid_valid_d = 1'b0;
      end

      case (state_q)
         FETCH: begin
            req_d = 1'b1;
            if (w_redirect) begin
               // An unanswered request must still be drained at its old address.
               if (req_q && !fif.ImemReady) state_d = DISCARD;
               else                         addr_d  = w_target;
            end else if (fif.Stall) begin
               if (req_q && fif.ImemReady) begin
                  w_skid_load = 1'b1;
                  req_d       = 1'b0;
                  state_d     = HOLD;
               end
            end else if (req_q && fif.ImemReady) begin
               ifid_instr_d = fif.ImemData;
               ifid_pc_d    = addr_q;
               ifid_valid_d = 1'b1;
               pc_d         = pc_q + 32'd4;
               addr_d       = pc_q + 32'd4;
            end else begin
               ifid_instr_d = 32'h0;
               ifid_pc_d    = pc_q;
               ifid_valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (w_redirect) begin
               addr_d  = w_target;
               req_d   = 1'b1;
               state_d = FETCH;
            end else if (!fif.Stall) begin
               ifid_instr_d = w_skid_data;
               ifid_pc_d    = w_skid_pc;
               ifid_valid_d = w_skid_valid;
               w_skid_clear = 1'b1;
               pc_d         = pc_q + 32'd4;
               addr_d       = pc_q + 32'd4;
               req_d        = 1'b1;
               state_d      = FETCH;
            end
         end
         DISCARD: begin
            if (!w_redirect && !fif.Stall) begin
               ifid_instr_d = 32'h0;
               ifid_pc_d    = pc_q;
               ifid_valid_d = 1'b0;
            end
            // The returning word is dropped; pc_d already holds the latest target.
            if (fif.ImemReady) begin
               state_d = FETCH;
               addr_d  = pc_d;
            end
         end
         default: begin
            state_d = FETCH;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FETCH;
         pc_q         <= word_align(RESET_PC);
         addr_q       <= word_align(RESET_PC);
         req_q        <= 1'b0;
         ifid_instr_q <= 32'h0;
         ifid_pc_q    <= word_align(RESET_PC);
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   fetch_skid_buffer u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  (fif.ImemData),
      .i_pc    (addr_q),
      .o_data  (w_skid_data),
      .o_pc    (w_skid_pc),
      .o_valid (w_skid_valid)
   );

   assign fif.ImemReq          = req_q;
   assign fif.ImemAddr         = addr_q;
   assign fif.IFID_Instruction = ifid_instr_q;
   assign fif.IFID_PC          = ifid_pc_q;
   assign fif.IFID_Valid       = ifid_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// tb_instruction_fetch : directed scenarios plus random stream scoreboard
// Rev 1.0
// =====================================================================
module tb_instruction_fetch;
   import if_pkg::*;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC = 32'h8000_0004;
   localparam logic [31:0] INT_VEC = 32'h8000_0008;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instruction_fetch_if bus ();

   instruction_fetch #(
      .RESET_PC   (RST_PC),
      .EXC_VECTOR (EXC_VEC),
      .INT_VECTOR (INT_VEC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fif   (bus)
   );

   int n_cmp   = 0;
   int n_err   = 0;
   int n_deliv = 0;
   int lat_cnt = 0;

   bit          sb_en      = 1'b0;
   bit          edge_stall = 1'b1;
   bit          edge_redir = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   // Reference rules: which inputs redirect, and where to.
   function automatic bit ref_redirect(input bit stall, input bit exc, input bit intr,
                                       input logic [1:0] jump, input bit br, input bit bc);
      return !stall && (exc || intr || jump == 2'b01 || jump == 2'b10 || (br && bc));
   endfunction

   function automatic logic [31:0] ref_target(input bit exc, input bit intr, input logic [1:0] jump,
                                              input logic [31:0] jt, input logic [31:0] jr);
      if (exc)                return EXC_VEC;
      else if (intr)          return INT_VEC;
      else if (jump == 2'b10) return jr;
      else                    return jt;
   endfunction

   task automatic clear_ctrl();
      bus.Stall      = 1'b0;
      bus.Branch     = 1'b0;
      bus.BranchCond = 1'b0;
      bus.Jump       = 2'b00;
      bus.JumpTarget = 32'h0;
      bus.JumpReg    = 32'h0;
      bus.Exception  = 1'b0;
      bus.Interrupt  = 1'b0;
   endtask

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(exp_pc);
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   // Monitor: every IF/ID update not frozen by Stall is checked against the stream.
   always @(negedge clk) begin
      logic [31:0] e;
      if (sb_en && !edge_stall) begin
         if (edge_redir) check("redirect_bubble", 32'(bus.IFID_Valid), 32'h0);
         if (bus.IFID_Valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_empty: got PC %08h with no instruction expected", bus.IFID_PC);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", bus.IFID_PC, e);
               check("sb_instr", bus.IFID_Instruction, mem_word(e));
               n_deliv++;
            end
         end else begin
            check("bubble_instr", bus.IFID_Instruction, 32'h0);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          pend_redir;
      logic [31:0] pend_tgt;

      clear_ctrl();
      bus.ImemReady = 1'b1;
      bus.ImemData  = 32'h2008_0005;
      repeat (3) @(negedge clk);
      check("rst_req",   32'(bus.ImemReq), 32'h0);
      check("rst_addr",  bus.ImemAddr, RST_PC);
      check("rst_instr", bus.IFID_Instruction, 32'h0);
      check("rst_pc",    bus.IFID_PC, RST_PC);
      check("rst_valid", 32'(bus.IFID_Valid), 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(FETCH));

      // Back-to-back fetch with memory always ready
      reset = 1'b1;
      @(negedge clk);
      check("first_req", 32'(bus.ImemReq), 32'h1);
      check("addr_0", bus.ImemAddr, 32'h0);
      @(negedge clk);
      check("addr_4", bus.ImemAddr, 32'h4);
      check("ifid_pc_0", bus.IFID_PC, 32'h0);
      check("ifid_valid_0", 32'(bus.IFID_Valid), 32'h1);
      check("ifid_instr_0", bus.IFID_Instruction, 32'h2008_0005);
      @(negedge clk);
      check("addr_8", bus.ImemAddr, 32'h8);
      @(negedge clk);
      @(negedge clk);
      check("addr_10", bus.ImemAddr, 32'h10);

      // Stall while the word at 0x10 returns
      bus.Stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("hold_state", 32'(dut.state_q), 32'(HOLD));
         check("hold_req", 32'(bus.ImemReq), 32'h0);
         check("hold_ifid_pc", bus.IFID_PC, 32'hC);
      end
      bus.Stall = 1'b0;
      @(negedge clk);
      check("release_pc", bus.IFID_PC, 32'h10);
      check("release_valid", 32'(bus.IFID_Valid), 32'h1);
      check("release_addr", bus.ImemAddr, 32'h14);
      check("release_req", 32'(bus.ImemReq), 32'h1);

      // Taken branch coinciding with ready
      bus.Branch = 1'b1; bus.BranchCond = 1'b1; bus.JumpTarget = 32'h40;
      @(negedge clk);
      clear_ctrl();
      check("br_addr", bus.ImemAddr, 32'h40);
      check("br_bubble", 32'(bus.IFID_Valid), 32'h0);
      @(negedge clk);
      check("br_valid", 32'(bus.IFID_Valid), 32'h1);
      check("br_pc", bus.IFID_PC, 32'h40);

      // Register jump with a slow request outstanding at 0x20
      bus.Jump = 2'b01; bus.JumpTarget = 32'h20;
      @(negedge clk);
      clear_ctrl();
      bus.ImemReady = 1'b0;
      check("j_addr", bus.ImemAddr, 32'h20);
      @(negedge clk);
      bus.Jump = 2'b10; bus.JumpReg = 32'h100;
      @(negedge clk);
      clear_ctrl();
      check("disc_state", 32'(dut.state_q), 32'(DISCARD));
      check("disc_addr", bus.ImemAddr, 32'h20);
      check("disc_req", 32'(bus.ImemReq), 32'h1);
      @(negedge clk);
      check("disc_addr_hold", bus.ImemAddr, 32'h20);
      bus.ImemReady = 1'b1; bus.ImemData = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.ImemData = 32'h1111_1111;
      check("disc_new_addr", bus.ImemAddr, 32'h100);
      check("disc_dropped", 32'(bus.IFID_Valid), 32'h0);
      check("disc_to_fetch", 32'(dut.state_q), 32'(FETCH));
      @(negedge clk);
      check("jr_pc", bus.IFID_PC, 32'h100);
      check("jr_instr", bus.IFID_Instruction, 32'h1111_1111);

      // All redirect sources at once, first stalled, then live
      bus.ImemReady = 1'b0;
      bus.Stall = 1'b1; bus.Exception = 1'b1; bus.Interrupt = 1'b1;
      bus.Jump = 2'b01; bus.JumpTarget = 32'h200;
      @(negedge clk);
      check("stall_pc", dut.pc_q, 32'h104);
      check("stall_addr", bus.ImemAddr, 32'h104);
      check("stall_ifid", bus.IFID_PC, 32'h100);
      bus.Stall = 1'b0;
      @(negedge clk);
      clear_ctrl();
      check("exc_pc", dut.pc_q, EXC_VEC);
      check("exc_bubble", 32'(bus.IFID_Valid), 32'h0);
      bus.ImemReady = 1'b1;
      @(negedge clk);
      check("exc_addr", bus.ImemAddr, EXC_VEC);

      // Reset pulse with a request outstanding
      bus.ImemReady = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_req",   32'(bus.ImemReq), 32'h0);
      check("mid_rst_addr",  bus.ImemAddr, RST_PC);
      check("mid_rst_instr", bus.IFID_Instruction, 32'h0);
      check("mid_rst_pc",    bus.IFID_PC, RST_PC);
      check("mid_rst_valid", 32'(bus.IFID_Valid), 32'h0);
      @(negedge clk);
      bus.ImemReady = 1'b1; bus.ImemData = 32'h2222_2222;
      reset = 1'b1;
      @(negedge clk);
      check("restart_req", 32'(bus.ImemReq), 32'h1);
      check("restart_addr", bus.ImemAddr, RST_PC);
      @(negedge clk);
      check("restart_pc", bus.IFID_PC, RST_PC);
      check("restart_instr", bus.IFID_Instruction, 32'h2222_2222);

      // Random phase against the instruction-stream scoreboard
      reset = 1'b0;
      bus.ImemReady = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      exp_pc = RST_PC;
      refill();
      edge_stall = 1'b1;
      edge_redir = 1'b0;
      reset = 1'b1;
      sb_en = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         @(negedge clk);
         if (bus.ImemReq) begin
            if (lat_cnt == 0) begin
               bus.ImemReady = 1'b1;
               bus.ImemData  = mem_word(bus.ImemAddr);
               lat_cnt       = $urandom_range(0, 3);
            end else begin
               bus.ImemReady = 1'b0;
               bus.ImemData  = $urandom;
               lat_cnt--;
            end
         end else begin
            bus.ImemReady = ($urandom_range(0, 1) == 1);
            bus.ImemData  = $urandom;
         end
         bus.Stall      = ($urandom_range(0, 3) == 0);
         bus.Exception  = ($urandom_range(0, 39) == 0);
         bus.Interrupt  = ($urandom_range(0, 39) == 0);
         r = $urandom_range(0, 19);
         bus.Jump       = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
         bus.Branch     = ($urandom_range(0, 7) == 0);
         bus.BranchCond = ($urandom_range(0, 1) == 1);
         bus.JumpTarget = $urandom & 32'hFFFF_FFFC;
         bus.JumpReg    = $urandom & 32'hFFFF_FFFC;
         pend_redir = ref_redirect(bus.Stall, bus.Exception, bus.Interrupt,
                                   bus.Jump, bus.Branch, bus.BranchCond);
         pend_tgt   = ref_target(bus.Exception, bus.Interrupt, bus.Jump,
                                 bus.JumpTarget, bus.JumpReg);
         @(posedge clk);
         edge_stall = bus.Stall;
         edge_redir = pend_redir;
         if (pend_redir) begin
            exp_q.delete();
            exp_pc = pend_tgt;
         end
         refill();
      end
      @(negedge clk);
      sb_en = 1'b0;
      check("deliveries_min", 32'(n_deliv >= 200), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
